// File: rtl/div_step_counter.sv
// Divider iteration sequencer: start/done handshake, STEPS iterations, first/last flags, stall freezes the count.
// Latency: busy the cycle after start, done after STEPS unstalled cycles; optional abort via DIV_STEP_ABORT_EN.
module div_step_counter #(
  parameter int WIDTH = 5,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             ack,
`ifdef DIV_STEP_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] i,
  output logic             step,
  output logic             busy,
  output logic             first,
  output logic             last,
  output logic             done
);

  generate
    if (WIDTH < 1 || WIDTH > 30 || STEPS < 1 || STEPS > (1 << WIDTH)) begin : g_bad_cfg
      $error("div_step_counter: STEPS must be in 1..2**WIDTH");
    end
  endgenerate

  // Compared at WIDTH bits so STEPS == 2**WIDTH maps to an all-ones index.
  localparam logic [WIDTH-1:0] LAST_I = WIDTH'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   kill;

`ifdef DIV_STEP_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            state <= RUN;
            i     <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
            i     <= '0;
            busy  <= 1'b0;
          end else if (!stall) begin
            if (i == LAST_I) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              i <= i + WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (kill) begin
            state <= IDLE;
            i     <= '0;
            done  <= 1'b0;
          end else if (ack) begin
            i     <= '0;
            done  <= 1'b0;
            state <= start ? RUN : IDLE;
            busy  <= start;
          end
        end
        default: begin
          state <= IDLE;
          i     <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign step  = busy & ~stall;
  assign first = busy & (i == '0);
  assign last  = busy & (i == LAST_I);

endmodule

// File: tb/tb_div_step_counter.sv
// Scoreboard bench for div_step_counter: three instances (5/32, 3/8, 3/1) on shared stimulus, one checked at a time.
module tb_div_step_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic ack = 1'b0;
  logic abort = 1'b0;
  int   sel = 0;

  logic [4:0] i0;
  logic [2:0] i1, i2;
  logic step0, busy0, first0, last0, done0;
  logic step1, busy1, first1, last1, done1;
  logic step2, busy2, first2, last2, done2;

  always #5 clk = ~clk;

  div_step_counter #(.WIDTH(5), .STEPS(32)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .ack(ack),
`ifdef DIV_STEP_ABORT_EN
    .abort(abort),
`endif
    .i(i0), .step(step0), .busy(busy0), .first(first0), .last(last0), .done(done0));

  div_step_counter #(.WIDTH(3), .STEPS(8)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .ack(ack),
`ifdef DIV_STEP_ABORT_EN
    .abort(abort),
`endif
    .i(i1), .step(step1), .busy(busy1), .first(first1), .last(last1), .done(done1));

  div_step_counter #(.WIDTH(3), .STEPS(1)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .ack(ack),
`ifdef DIV_STEP_ABORT_EN
    .abort(abort),
`endif
    .i(i2), .step(step2), .busy(busy2), .first(first2), .last(last2), .done(done2));

  typedef struct packed {
    logic [7:0] i;
    logic       step;
    logic       busy;
    logic       first;
    logic       last;
    logic       done;
    logic [1:0] sel;
  } obs_t;

  obs_t q[$];
  obs_t exp_e, act_e;
  int   checks = 0;
  int   errors = 0;

  function automatic int last_idx(input int s);
    return (s == 0) ? 31 : (s == 1) ? 7 : 0;
  endfunction

  // Drives one cycle's inputs just after the edge and queues the outputs expected during that cycle.
  task automatic cyc(input logic r, st, sl, ak, ab, input int ei, input logic eb, ed);
    obs_t e;
    @(posedge clk);
    #1;
    reset = r; start = st; stall = sl; ack = ak; abort = ab;
    e.i     = 8'(ei);
    e.busy  = eb;
    e.done  = ed;
    e.step  = eb & ~sl;
    e.first = eb && (ei == 0);
    e.last  = eb && (ei == last_idx(sel));
    e.sel   = 2'(sel);
    q.push_back(e);
  endtask

  task automatic run(input int j);
    cyc(0, 0, 0, 0, 0, j, 1, 0);
  endtask

  task automatic idle(input logic st);
    cyc(0, st, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_e = q.pop_front();
      act_e = '0;
      act_e.sel = exp_e.sel;
      case (exp_e.sel)
        2'd0: begin
          act_e.i = {3'b0, i0}; act_e.step = step0; act_e.busy = busy0;
          act_e.first = first0; act_e.last = last0; act_e.done = done0;
        end
        2'd1: begin
          act_e.i = {5'b0, i1}; act_e.step = step1; act_e.busy = busy1;
          act_e.first = first1; act_e.last = last1; act_e.done = done1;
        end
        default: begin
          act_e.i = {5'b0, i2}; act_e.step = step2; act_e.busy = busy2;
          act_e.first = first2; act_e.last = last2; act_e.done = done2;
        end
      endcase
      checks++;
      if (act_e !== exp_e) begin
        errors++;
        $display("FAIL dut%0d t=%0t got i=%0d step=%b busy=%b first=%b last=%b done=%b want i=%0d step=%b busy=%b first=%b last=%b done=%b",
                 exp_e.sel, $time, act_e.i, act_e.step, act_e.busy, act_e.first, act_e.last, act_e.done,
                 exp_e.i, exp_e.step, exp_e.busy, exp_e.first, exp_e.last, exp_e.done);
      end
    end
  end

  initial begin
    // Reset and plain 32-step run
    sel = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(1);
    for (int j = 0; j < 32; j++) run(j);
    cyc(0, 0, 0, 1, 0, 31, 0, 1);
    idle(0);
    idle(0);

    // Stalls at i=7 (3 cycles) and at last (2 cycles)
    idle(1);
    for (int j = 0; j < 7; j++) run(j);
    repeat (3) cyc(0, 0, 1, 0, 0, 7, 1, 0);
    run(7);
    for (int j = 8; j < 31; j++) run(j);
    repeat (2) cyc(0, 0, 1, 0, 0, 31, 1, 0);
    run(31);

    // DONE held 4 cycles, then back-to-back start with ack
    repeat (4) cyc(0, 0, 0, 0, 0, 31, 0, 1);
    cyc(0, 1, 0, 1, 0, 31, 0, 1);
    for (int j = 0; j < 32; j++) run(j);
    cyc(0, 0, 0, 1, 0, 31, 0, 1);
    idle(0);

    // WIDTH=3 STEPS=8: reaches 7 without wrapping
    sel = 1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(1);
    for (int j = 0; j < 8; j++) run(j);
    cyc(0, 0, 0, 0, 0, 7, 0, 1);
    cyc(0, 0, 0, 1, 0, 7, 0, 1);
    idle(0);

    // STEPS=1: single RUN cycle with first=last=step=1
    sel = 2;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(1);
    run(0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1);
    idle(0);

    // Asynchronous reset mid-run at i=12; start under reset is ignored
    sel = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(1);
    for (int j = 0; j < 12; j++) run(j);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);

`ifdef DIV_STEP_ABORT_EN
    // Abort beats stall in RUN, is ignored in IDLE, and beats ack+start in DONE
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(1);
    for (int j = 0; j < 5; j++) run(j);
    cyc(0, 0, 1, 0, 1, 5, 1, 0);
    idle(0);
    cyc(0, 1, 0, 0, 1, 0, 0, 0);
    idle(0);
    idle(1);
    for (int j = 0; j < 32; j++) run(j);
    cyc(0, 1, 0, 1, 1, 31, 0, 1);
    idle(0);
    idle(0);
`endif

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_step_counter.md
# div_step_counter

Parametrised iteration sequencer for the signed divider datapath, replacing the free-running 5-bit iteration counter. It counts a programmable number of steps per operation and supports datapath stalls. It also provides a start/done handshake and first/last step flags, so the divider control logic needs no comparators of its own. It sits between the divider's top-level control and its shift/subtract datapath.

## Interface
Parameters:
- WIDTH, 5, bit width of the step index `i`
- STEPS, 32, iterations per operation; legal range 1..2^WIDTH; an out-of-range value is an elaboration error

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request a new operation; sampled in IDLE, and in DONE when `ack` is also high
- stall  input  1  datapath not ready; freezes the count in RUN
- ack  input  1  consumer has taken the result; releases DONE
- i  output  WIDTH  current step index
- step  output  1  the datapath performs iteration `i` this cycle (busy & ~stall)
- busy  output  1  high in RUN
- first  output  1  busy & (i == 0)
- last  output  1  busy & (i == STEPS-1)
- done  output  1  high in DONE

## Operation
- Three states: IDLE, RUN and DONE. Reset enters IDLE with i=0 and busy=done=0, so first=last=step=0.
- IDLE:
  - start=1 → RUN with i=0.
  - Otherwise hold.
- RUN:
  - stall=1 → hold `i` and state. This applies also when last=1.
  - stall=0 and i<STEPS-1 → i+1.
  - stall=0 and i==STEPS-1 → DONE. `i` holds at STEPS-1.
  - start is ignored.
- DONE:
  - ack=0 → hold; done stays high.
  - ack=1, start=0 → IDLE with i=0.
  - ack=1, start=1 → RUN with i=0 (back-to-back operation, no idle cycle).
- Arithmetic:
  - `i` is unsigned, WIDTH bits, and never wraps; it is bounded by STEPS-1.
  - The comparison with STEPS-1 is done at WIDTH bits, so STEPS=2^WIDTH is legal.
- STEPS=1: the single RUN cycle has first=last=1.
- All outputs are decoded from registered state only; no output depends combinationally on an input except `step`, which depends on `stall`.

## Timing
- Reset asserted at any time, including mid-RUN or in DONE: outputs reach their reset values without waiting for a clock edge.
- Reset release: the first active edge after deassertion evaluates IDLE normally.
- start is sampled at edge k → busy=1 and first=1 after edge k.
- With no stalls:
  - RUN lasts exactly STEPS cycles.
  - done=1 after edge k+STEPS.
- Each stalled cycle extends RUN by exactly one cycle.
- done stays high for at least one cycle and until ack is sampled.
- Minimum turnaround from done to the next busy is 0 cycles, using the DONE start+ack path.

## Configuration
- Macro: DIV_STEP_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit), placed after `ack`.
  - abort=1 sampled in RUN or DONE → IDLE with i=0 at the next edge.
  - abort has priority over stall, ack and start.
  - abort in IDLE is ignored; the block does not start even if start=1 in the same cycle.
- Undefined: the port is absent, and behaviour is exactly as described above.

## Test plan
- Reset, then WIDTH=5, STEPS=32: start pulse at edge k → i counts 0..31 on edges k+1..k+32, first only at i=0, last only at i=31, done=1 after edge k+32, i holds at 31.
- Stall for 3 cycles at i=7 and 2 cycles while last=1 → i holds at 7, step=0 during the stalls, done is delayed by exactly 5 cycles (after edge k+37).
- In DONE, hold ack=0 for 4 cycles, then ack=1 with start=1 → done stays high throughout, then busy=1, i=0, first=1 on the next edge with no IDLE cycle.
- WIDTH=3, STEPS=8, then STEPS=1 → i reaches 7 with no wrap and done follows; with STEPS=1 the single RUN cycle has first=last=step=1.
- Assert reset asynchronously (between clock edges) at i=12 in RUN → i=0, busy=0, done=0 immediately; start before reset release is not honoured.
- With DIV_STEP_ABORT_EN: abort with stall=1 at i=5 → IDLE and i=0 next edge; abort in DONE with ack=1 and start=1 → IDLE, not RUN.
